// File: rtl/shift_pkg.sv
// Shared encodings for the shift command sequencer: command ops, universal_shift
// select codes and the sequencer FSM states.
package shift_pkg;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_SHR   = 2'b01;
   localparam logic [1:0] OP_SHL   = 2'b10;
   localparam logic [1:0] OP_ROTR  = 2'b11;

   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_SHR  = 2'b01;
   localparam logic [1:0] SEL_SHL  = 2'b10;
   localparam logic [1:0] SEL_LOAD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_EXEC    = 2'b01,
      ST_CAPTURE = 2'b10
   } state_t;

   // A rotate-right is a right shift whose serial input is the outgoing LSB.
   function automatic logic [1:0] opToSel(input logic [1:0] op);
      case (op)
         OP_LOAD: opToSel = SEL_LOAD;
         OP_SHR:  opToSel = SEL_SHR;
         OP_SHL:  opToSel = SEL_SHL;
         default: opToSel = SEL_SHR;
      endcase
   endfunction

endpackage

// File: rtl/universal_shift.sv
// 4-bit universal shift register (hold / shift-right / shift-left / parallel load)
// that the command sequencer drives.
module universal_shift
   import shift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] data_in,
   input  logic             shift_right,
   input  logic             shift_left,
   output logic [WIDTH-1:0] data_out
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q <= '0;
      end else begin
         case (sel)
            SEL_SHR:  r_q <= {shift_right, r_q[WIDTH-1:1]};
            SEL_SHL:  r_q <= {r_q[WIDTH-2:0], shift_left};
            SEL_LOAD: r_q <= data_in;
            default:  r_q <= r_q;
         endcase
      end
   end

   assign data_out = r_q;

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Command front-end for universal_shift: accepts one load/shift/rotate command per
// handshake, steps the register for the requested count, then returns its value with done.
module shift_cmd_sequencer
   import shift_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             cmd_fill,
   output logic [1:0]       sr_sel,
   output logic [WIDTH-1:0] sr_data_in,
   output logic             sr_shift_right,
   output logic             sr_shift_left,
   input  logic [WIDTH-1:0] sr_data_out,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   state_t           r_state;
   logic [1:0]       r_sel;
   logic [WIDTH-1:0] r_dataIn;
   logic [1:0]       r_op;
   logic             r_fill;
   logic [CNT_W-1:0] r_remaining;
   logic             r_done;
   logic [WIDTH-1:0] r_result;

   state_t           w_stateNext;
   logic [1:0]       w_selNext;
   logic [WIDTH-1:0] w_dataInNext;
   logic [1:0]       w_opNext;
   logic             w_fillNext;
   logic [CNT_W-1:0] w_remNext;
   logic             w_doneNext;
   logic [WIDTH-1:0] w_resultNext;
   logic             w_cmdReady;
   logic             w_accept;
   logic [CNT_W-1:0] w_startCount;

   // Ready stays low during the done cycle so a new command cannot overlap the result.
   assign w_cmdReady   = (r_state == ST_IDLE) && !r_done;
   assign w_accept     = cmd_valid && w_cmdReady;
   assign w_startCount = (cmd_op == OP_LOAD) ? CNT_W'(1) : cmd_count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_sel       <= SEL_HOLD;
         r_dataIn    <= '0;
         r_op        <= OP_LOAD;
         r_fill      <= 1'b0;
         r_remaining <= '0;
         r_done      <= 1'b0;
         r_result    <= '0;
      end else begin
         r_state     <= w_stateNext;
         r_sel       <= w_selNext;
         r_dataIn    <= w_dataInNext;
         r_op        <= w_opNext;
         r_fill      <= w_fillNext;
         r_remaining <= w_remNext;
         r_done      <= w_doneNext;
         r_result    <= w_resultNext;
      end
   end

   always_comb begin
      w_stateNext  = r_state;
      w_selNext    = r_sel;
      w_dataInNext = r_dataIn;
      w_opNext     = r_op;
      w_fillNext   = r_fill;
      w_remNext    = r_remaining;
      w_doneNext   = 1'b0;
      w_resultNext = r_result;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_opNext     = cmd_op;
               w_fillNext   = cmd_fill;
               w_dataInNext = cmd_data;
               w_remNext    = w_startCount;
               if (w_startCount == '0) begin
                  w_selNext   = SEL_HOLD;
                  w_stateNext = ST_CAPTURE;
               end else begin
                  w_selNext   = opToSel(cmd_op);
                  w_stateNext = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            if (r_remaining <= CNT_W'(1)) begin
               w_remNext   = '0;
               w_selNext   = SEL_HOLD;
               w_stateNext = ST_CAPTURE;
            end else begin
               w_remNext = r_remaining - CNT_W'(1);
            end
         end
         ST_CAPTURE: begin
            w_resultNext = sr_data_out;
            w_doneNext   = 1'b1;
            w_stateNext  = ST_IDLE;
         end
         default: begin
            w_selNext   = SEL_HOLD;
            w_stateNext = ST_IDLE;
         end
      endcase
   end

   // The rotate feedback bit has to track the register combinationally each cycle.
   assign sr_shift_right = (r_op == OP_ROTR) ? sr_data_out[0] :
                           ((r_op == OP_SHR) ? r_fill : 1'b0);
   assign sr_shift_left  = (r_op == OP_SHL) ? r_fill : 1'b0;

   assign cmd_ready  = w_cmdReady;
   assign busy       = !w_cmdReady;
   assign sr_sel     = r_sel;
   assign sr_data_in = r_dataIn;
   assign done       = r_done;
   assign result     = r_result;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed bench: shift_cmd_sequencer driving universal_shift, checking handshake,
// select sequencing, latency, results and reset abort.
module tb_shift_cmd_sequencer;
   import shift_pkg::*;

   logic       clk;
   logic       rst;
   logic       srRst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_data;
   logic [2:0] cmd_count;
   logic       cmd_fill;
   logic [1:0] sr_sel;
   logic [3:0] sr_data_in;
   logic       sr_shift_right;
   logic       sr_shift_left;
   logic [3:0] sr_data_out;
   logic       busy;
   logic       done;
   logic [3:0] result;

   int assertCount;
   int failCount;
   int edges;
   int selCycles;
   int doneCount;
   int guard;

   shift_cmd_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
      .sr_sel(sr_sel), .sr_data_in(sr_data_in), .sr_shift_right(sr_shift_right),
      .sr_shift_left(sr_shift_left), .sr_data_out(sr_data_out), .busy(busy),
      .done(done), .result(result)
   );

   universal_shift #(.WIDTH(4)) shifter (
      .clk(clk), .rst(srRst), .sel(sr_sel), .data_in(sr_data_in),
      .shift_right(sr_shift_right), .shift_left(sr_shift_left), .data_out(sr_data_out)
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Presents a command and returns at the negedge after the accept edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [3:0] data,
                                input logic [2:0] count, input logic fill);
      int g;
      @(negedge clk);
      cmd_op    = op;
      cmd_data  = data;
      cmd_count = count;
      cmd_fill  = fill;
      cmd_valid = 1'b1;
      g = 0;
      while (!cmd_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) checkOutput("ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Counts edges after accept until done and the cycles with a non-hold select.
   task automatic waitDone(input logic [1:0] expSel, output int nEdges, output int nSel);
      nEdges = 0;
      nSel   = 0;
      while (!done && nEdges < 40) begin
         if (sr_sel !== SEL_HOLD) begin
            nSel++;
            checkOutput("sel_value", 32'(sr_sel), 32'(expSel));
         end
         @(negedge clk);
         nEdges++;
      end
      if (nEdges >= 40) checkOutput("done_timeout", 32'd0, 32'd1);
      checkOutput("ready_low_in_done", 32'(cmd_ready), 32'd0);
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      rst       = 1'b0;
      srRst     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = OP_LOAD;
      cmd_data  = 4'h0;
      cmd_count = 3'd0;
      cmd_fill  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst   = 1'b1;
      srRst = 1'b1;

      checkOutput("rst_sel", 32'(sr_sel), 32'd0);
      checkOutput("rst_data_in", 32'(sr_data_in), 32'd0);
      checkOutput("rst_fills", 32'({sr_shift_right, sr_shift_left}), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_result", 32'(result), 32'd0);
      checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);

      // 1: LOAD 1001
      applyStimulus(OP_LOAD, 4'b1001, 3'd5, 1'b1);
      checkOutput("load_busy", 32'(busy), 32'd1);
      waitDone(SEL_LOAD, edges, selCycles);
      checkOutput("load_edges", 32'(edges), 32'd2);
      checkOutput("load_sel_cycles", 32'(selCycles), 32'd1);
      checkOutput("load_result", 32'(result), 32'b1001);
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("ready_after_done", 32'(cmd_ready), 32'd1);

      // 2: LOAD 1001, SHR count 2 fill 1
      applyStimulus(OP_LOAD, 4'b1001, 3'd0, 1'b0);
      waitDone(SEL_LOAD, edges, selCycles);
      applyStimulus(OP_SHR, 4'b0000, 3'd2, 1'b1);
      checkOutput("shr_serial", 32'({sr_shift_right, sr_shift_left}), 32'b10);
      waitDone(SEL_SHR, edges, selCycles);
      checkOutput("shr_edges", 32'(edges), 32'd3);
      checkOutput("shr_sel_cycles", 32'(selCycles), 32'd2);
      checkOutput("shr_result", 32'(result), 32'b1110);

      // 3: LOAD 1101, SHL count 3 fill 0, then SHL count 0
      applyStimulus(OP_LOAD, 4'b1101, 3'd0, 1'b0);
      waitDone(SEL_LOAD, edges, selCycles);
      applyStimulus(OP_SHL, 4'b1111, 3'd3, 1'b0);
      waitDone(SEL_SHL, edges, selCycles);
      checkOutput("shl_edges", 32'(edges), 32'd4);
      checkOutput("shl_result", 32'(result), 32'b1000);
      applyStimulus(OP_SHL, 4'b1111, 3'd0, 1'b1);
      waitDone(SEL_SHL, edges, selCycles);
      checkOutput("shl0_edges", 32'(edges), 32'd1);
      checkOutput("shl0_sel_cycles", 32'(selCycles), 32'd0);
      checkOutput("shl0_result", 32'(result), 32'b1000);

      // 4: LOAD 1001, ROTR 1, then ROTR 4
      applyStimulus(OP_LOAD, 4'b1001, 3'd0, 1'b0);
      waitDone(SEL_LOAD, edges, selCycles);
      applyStimulus(OP_ROTR, 4'b0000, 3'd1, 1'b0);
      checkOutput("rotr_serial", 32'(sr_shift_right), 32'd1);
      waitDone(SEL_SHR, edges, selCycles);
      checkOutput("rotr1_result", 32'(result), 32'b1100);
      applyStimulus(OP_ROTR, 4'b0000, 3'd4, 1'b1);
      waitDone(SEL_SHR, edges, selCycles);
      checkOutput("rotr4_edges", 32'(edges), 32'd5);
      checkOutput("rotr4_sel_cycles", 32'(selCycles), 32'd4);
      checkOutput("rotr4_result", 32'(result), 32'b1100);

      // 5: cmd_valid held through SHR count 5 fill 1; fields changed mid-command
      @(negedge clk);
      cmd_op = OP_SHR; cmd_data = 4'b0000; cmd_count = 3'd5; cmd_fill = 1'b1;
      cmd_valid = 1'b1;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) checkOutput("hold_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_fill  = 1'b0;
      cmd_count = 3'd1;
      edges = 0;
      while (!done && edges < 40) begin
         checkOutput("hold_ready_low", 32'(cmd_ready), 32'd0);
         @(negedge clk);
         edges++;
      end
      if (edges >= 40) checkOutput("hold_done_timeout", 32'd0, 32'd1);
      checkOutput("hold_edges", 32'(edges), 32'd6);
      checkOutput("hold_ready_in_done", 32'(cmd_ready), 32'd0);
      checkOutput("hold_result", 32'(result), 32'b1111);
      cmd_op   = OP_LOAD;
      cmd_data = 4'b0101;
      @(negedge clk);
      checkOutput("hold_single_done", 32'(done), 32'd0);
      checkOutput("hold_ready_rises", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput("hold_next_accepted", 32'(busy), 32'd1);
      waitDone(SEL_LOAD, edges, selCycles);
      checkOutput("hold_next_result", 32'(result), 32'b0101);

      // 6: reset at the second active edge of SHR count 4
      applyStimulus(OP_SHR, 4'b0000, 3'd4, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      checkOutput("abort_sel", 32'(sr_sel), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_result", 32'(result), 32'd0);
      checkOutput("abort_ready", 32'(cmd_ready), 32'd1);
      doneCount = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) doneCount++;
      end
      checkOutput("abort_no_done", 32'(doneCount), 32'd0);
      applyStimulus(OP_LOAD, 4'b0110, 3'd0, 1'b0);
      waitDone(SEL_LOAD, edges, selCycles);
      checkOutput("recover_edges", 32'(edges), 32'd2);
      checkOutput("recover_result", 32'(result), 32'b0110);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
